conv_encoder_param: RTL and testbench
=====================================

# conv_encoder_param

Parametrised rate-1/N_OUT feed-forward convolutional encoder with frame handling, zero-tail termination and valid/ready flow control on both sides. It is the channel-side source for the Viterbi decoder path: it takes a serial bit stream and emits one N_OUT-bit code symbol per accepted input bit. For K=3, N_OUT=2, GEN={111,101} it is bit-exact with the existing fixed encoder. It adds configurable constraint length, generators, frame termination and backpressure.

## Interface
- K, 3: constraint length, legal range 3..9; shift memory is K-1 bits.
- N_OUT, 2: code bits per input bit, legal range 2..4.
- GEN, {3'b111,3'b101}: N_OUT*K packed generators. Generator j = GEN[(N_OUT-1-j)*K +: K]. Generator MSB taps the current input bit; LSB taps the oldest stored bit.
- TERMINATE, 1: 1 = append K-1 zero tail bits per frame; 0 = truncated frame.
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset is synchronous and active-low.
- i_valid  in  1  input bit valid.
- o_ready  out  1  encoder can accept an input bit this cycle.
- i_data  in  1  input bit.
- i_last  in  1  qualifies the accepted bit as the last bit of its frame.
- o_valid  out  1  code symbol valid.
- i_ready  in  1  downstream accepts the symbol.
- o_data  out  N_OUT  code symbol; o_data[N_OUT-1-j] = output of generator j.
- o_last  out  1  final symbol of the frame.
- o_busy  out  1  high when the state is not IDLE.

## Operation
- Registers:
  - sr[K-2:0]: sr[K-2] holds the most recent prior bit.
  - state: IDLE / ENC / TAIL.
  - tail_cnt: ceil(log2(K)) bits.
  - One-deep output register holding o_data, o_valid and o_last.
- Encoding window w = {b, sr}, where b is the input bit (i_data, or 0 in TAIL). Each output bit j = XOR-reduce(w & g_j). After each emitted symbol, sr <= {b, sr[K-2:1]}.
- Advance condition adv = !o_valid || i_ready.
- Input acceptance:
  - o_ready = i_rst_n && adv && (state != TAIL).
  - An input bit is accepted when i_valid && o_ready.
- State machine:
  - IDLE: sr = 0. On an accepted bit without i_last -> ENC. On an accepted bit with i_last -> TAIL if TERMINATE=1, else stay in IDLE.
  - ENC: encode each accepted bit. On an accepted i_last -> TAIL if TERMINATE=1, else -> IDLE.
  - TAIL:
    - Each cycle with adv, emit one symbol with b=0 and increment tail_cnt.
    - When tail_cnt = K-2 the symbol carries o_last=1. State -> IDLE, tail_cnt -> 0.
  - When TERMINATE=0, o_last is set on the symbol of the i_last bit, and sr is cleared in the same cycle as that update.
- Frame start: every frame starts from the all-zero state. This is guaranteed by the tail flush or by the clear.
- Stall: while o_valid && !i_ready, o_data and o_last hold and sr does not change. No bit is lost or duplicated.
- Reset (i_rst_n low at a clock edge): state=IDLE, sr=0, tail_cnt=0, o_valid=0, o_data=0, o_last=0. Reset overrides any in-flight frame, including in TAIL. o_ready=0 while i_rst_n is low; o_busy=0 after the reset edge.

## Timing
- Latency: the symbol for a bit accepted at edge n is valid after edge n (registered output, 1 cycle).
- Throughput: 1 symbol/cycle with i_ready held high.
- Frame overhead with TERMINATE=1: K-1 extra cycles, with o_ready=0 during TAIL.
- Back-to-back frames:
  - A new frame's first bit is accepted in the cycle after the o_last symbol is registered.
  - With TERMINATE=0, it is accepted in the cycle after i_last is accepted; there are no gap cycles.
- The output register updates only on adv. o_valid drops after a handshake when no new symbol is produced.

## Test plan
- K=3, GEN={111,101}, TERMINATE=1, frame 1,1,0,1,1,0,1,0 (i_last on the 8th bit), i_ready=1 -> o_data 11,01,01,00,01,01,00,10,11,00. o_last only on the 10th symbol. o_ready low for 2 cycles during the tail.
- Same configuration, frame 1,0,1,0,1,0,1,0 with i_ready low for 3 cycles after the 3rd symbol -> 11,10,00,10,00,10,00,10,11,00. o_data stable while stalled; no bits dropped.
- Single-bit frame: bit 1 with i_last -> 11,10,11 with o_last on the 3rd symbol. A second frame immediately after, with bit 1 -> 11 (zero start state).
- TERMINATE=0, frame 11011010 -> 8 symbols ending in 10 with o_last. The next frame's first bit 1 -> 11 with no gap cycle.
- Reset mid-tail: drop i_rst_n for 1 cycle during TAIL -> o_valid=0, o_busy=0, o_last=0 next cycle. A following single-bit frame with bit 1 -> 11,10,11.
- K=7, N_OUT=2, GEN={7'o171,7'o133}: single-bit frame with bit 1 -> 11,10,11,11,00,01,11. o_last on the 7th symbol.

Source files
------------

// File: rtl/conv_encoder_param_if.sv
// Bit-stream in / code-symbol out handshake bundle for conv_encoder_param.
// The slave modport is the encoder's view; the master modport is the source/sink side.
interface conv_encoder_param_if #(
  parameter int unsigned N_OUT = 2
);
  logic             i_valid;
  logic             o_ready;
  logic             i_data;
  logic             i_last;
  logic             o_valid;
  logic             i_ready;
  logic [N_OUT-1:0] o_data;
  logic             o_last;

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_last,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data,
    output o_last
  );

  modport master (
    output i_valid,
    output i_data,
    output i_last,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_last
  );
endinterface

// File: rtl/conv_encoder_param.sv
// Rate-1/N_OUT feed-forward convolutional encoder with optional zero-tail termination
// and valid/ready flow control on both the bit input and the symbol output.
module conv_encoder_param #(
  parameter int unsigned        K         = 3,
  parameter int unsigned        N_OUT     = 2,
  parameter logic [N_OUT*K-1:0] GEN       = {3'b111, 3'b101},
  parameter bit                 TERMINATE = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  conv_encoder_param_if.slave bus,
  output logic                o_busy
);

  localparam int unsigned    SrW      = K - 1;
  localparam int unsigned    TcW      = $clog2(K);
  localparam logic [TcW-1:0] TailLast = TcW'(K - 2);

  typedef enum logic [1:0] {StIdle, StEnc, StTail} state_e;

  state_e             state_q, state_d;
  logic [SrW-1:0]     sr_q, sr_d;
  logic [TcW-1:0]     tail_cnt_q, tail_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [N_OUT-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic               adv;
  logic               accept;
  logic               bit_in;
  logic [K-1:0]       window;
  logic [SrW-1:0]     sr_shift;
  logic [N_OUT-1:0]   code;

  // The output register may load whenever it is empty or being drained this cycle.
  assign adv         = !out_valid_q || bus.i_ready;
  assign bus.o_ready = i_rst_n && adv && (state_q != StTail);
  assign accept      = bus.i_valid && bus.o_ready;

  assign bit_in   = (state_q == StTail) ? 1'b0 : bus.i_data;
  assign window   = {bit_in, sr_q};
  assign sr_shift = {bit_in, sr_q[SrW-1:1]};

  // o_data[i] belongs to generator N_OUT-1-i, which sits at GEN[i*K +: K].
  always_comb begin
    code = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      code[i] = ^(window & GEN[i*K +: K]);
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (adv) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle, StEnc: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = code;
          out_last_d  = 1'b0;
          sr_d        = sr_shift;
          if (bus.i_last) begin
            if (TERMINATE) begin
              state_d = StTail;
            end else begin
              // Truncated frame: mark this symbol last and restart from the zero state.
              out_last_d = 1'b1;
              sr_d       = '0;
              state_d    = StIdle;
            end
          end else begin
            state_d = StEnc;
          end
        end
      end
      StTail: begin
        if (adv) begin
          out_valid_d = 1'b1;
          out_data_d  = code;
          out_last_d  = 1'b0;
          sr_d        = sr_shift;
          if (tail_cnt_q == TailLast) begin
            out_last_d = 1'b1;
            tail_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            tail_cnt_d = tail_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.o_valid = out_valid_q;
  assign bus.o_data  = out_data_q;
  assign bus.o_last  = out_last_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed scoreboard bench for conv_encoder_param: K=3 terminated, K=3 truncated and
// K=7 terminated instances share one clock and reset.
module tb_conv_encoder_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_encoder_param_if #(.N_OUT(2)) bus0 ();
  conv_encoder_param_if #(.N_OUT(2)) bus1 ();
  conv_encoder_param_if #(.N_OUT(2)) bus2 ();
  logic busy0, busy1, busy2;

  conv_encoder_param #(
    .K(3), .N_OUT(2), .GEN({3'b111, 3'b101}), .TERMINATE(1'b1)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave), .o_busy(busy0)
  );

  conv_encoder_param #(
    .K(3), .N_OUT(2), .GEN({3'b111, 3'b101}), .TERMINATE(1'b0)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave), .o_busy(busy1)
  );

  conv_encoder_param #(
    .K(7), .N_OUT(2), .GEN({7'o171, 7'o133}), .TERMINATE(1'b1)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus2.slave), .o_busy(busy2)
  );

  typedef struct packed {
    logic [1:0] d;
    logic       l;
  } sym_t;

  sym_t exp_q[3][$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_sym(input int sel, input logic [1:0] d, input logic l);
    sym_t s;
    s.d = d;
    s.l = l;
    exp_q[sel].push_back(s);
  endtask

  task automatic mon(input int sel, input logic v, input logic r, input logic [1:0] d,
                     input logic l);
    sym_t e;
    if (v && r) begin
      n_asserts++;
      assert (exp_q[sel].size() != 0)
      else begin
        n_fail++;
        $error("FAIL dut%0d_unexpected_symbol: observed %b expected none", sel, d);
      end
      if (exp_q[sel].size() != 0) begin
        e = exp_q[sel].pop_front();
        check($sformatf("dut%0d_data", sel), 32'(d), 32'(e.d));
        check($sformatf("dut%0d_last", sel), 32'(l), 32'(e.l));
      end
    end
  endtask

  always @(negedge clk) mon(0, bus0.o_valid, bus0.i_ready, bus0.o_data, bus0.o_last);
  always @(negedge clk) mon(1, bus1.o_valid, bus1.i_ready, bus1.o_data, bus1.o_last);
  always @(negedge clk) mon(2, bus2.o_valid, bus2.i_ready, bus2.o_data, bus2.o_last);

  task automatic drive(input int sel, input logic v, input logic b, input logic l);
    case (sel)
      0: begin bus0.i_valid = v; bus0.i_data = b; bus0.i_last = l; end
      1: begin bus1.i_valid = v; bus1.i_data = b; bus1.i_last = l; end
      default: begin bus2.i_valid = v; bus2.i_data = b; bus2.i_last = l; end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return bus0.o_ready;
      1:       return bus1.o_ready;
      default: return bus2.o_ready;
    endcase
  endfunction

  // Called and returns at 2 time units after a rising edge; the bit is taken at the
  // rising edge just before return.
  task automatic send(input int sel, input logic b, input logic l, output int waits);
    logic r;
    waits = 0;
    drive(sel, 1'b1, b, l);
    @(negedge clk);
    r = rdy(sel);
    while (!r && waits < 50) begin
      @(posedge clk);
      #2;
      waits++;
      @(negedge clk);
      r = rdy(sel);
    end
    check($sformatf("dut%0d_accept_timeout", sel), 32'(r), 32'd1);
    @(posedge clk);
    #2;
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input int sel, input logic [15:0] bits, input int n,
                           input logic last_on_final);
    int w;
    for (int i = 0; i < n; i++) begin
      send(sel, bits[n-1-i], last_on_final && (i == n - 1), w);
    end
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0);
    bus0.i_ready = 1'b1;
    bus1.i_ready = 1'b1;
    bus2.i_ready = 1'b1;

    // Reset
    #1;
    check("ready_in_reset", 32'(bus0.o_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid0", 32'(bus0.o_valid), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_data0", 32'(bus0.o_data), 32'd0);
    check("rst_last0", 32'(bus0.o_last), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus0.o_ready), 32'd1);
    @(posedge clk);
    #2;

    // Terminated frame 11011010, tail 11,00
    expect_sym(0, 2'b11, 0); expect_sym(0, 2'b01, 0); expect_sym(0, 2'b01, 0);
    expect_sym(0, 2'b00, 0); expect_sym(0, 2'b01, 0); expect_sym(0, 2'b01, 0);
    expect_sym(0, 2'b00, 0); expect_sym(0, 2'b10, 0); expect_sym(0, 2'b11, 0);
    expect_sym(0, 2'b00, 1);
    send_bits(0, 16'b11011010, 8, 1'b1);
    @(negedge clk);
    check("tail_ready_c1", 32'(bus0.o_ready), 32'd0);
    check("tail_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    check("tail_ready_c2", 32'(bus0.o_ready), 32'd0);
    @(negedge clk);
    check("tail_ready_c3", 32'(bus0.o_ready), 32'd1);
    @(posedge clk);
    #2;

    // Frame 10101010 with a 3-cycle output stall after the third symbol
    expect_sym(0, 2'b11, 0); expect_sym(0, 2'b10, 0); expect_sym(0, 2'b00, 0);
    expect_sym(0, 2'b10, 0); expect_sym(0, 2'b00, 0); expect_sym(0, 2'b10, 0);
    expect_sym(0, 2'b00, 0); expect_sym(0, 2'b10, 0); expect_sym(0, 2'b11, 0);
    expect_sym(0, 2'b00, 1);
    send_bits(0, 16'b101, 3, 1'b0);
    bus0.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data", 32'(bus0.o_data), 32'd0);
      check("stall_valid", 32'(bus0.o_valid), 32'd1);
      check("stall_ready", 32'(bus0.o_ready), 32'd0);
    end
    @(posedge clk);
    #2;
    bus0.i_ready = 1'b1;
    send_bits(0, 16'b01010, 5, 1'b1);

    // Two back-to-back single-bit frames
    expect_sym(0, 2'b11, 0); expect_sym(0, 2'b10, 0); expect_sym(0, 2'b11, 1);
    expect_sym(0, 2'b11, 0); expect_sym(0, 2'b10, 0); expect_sym(0, 2'b11, 1);
    send(0, 1'b1, 1'b1, w);
    send(0, 1'b1, 1'b1, w);

    // Truncated frame, next frame accepted without a gap cycle
    expect_sym(1, 2'b11, 0); expect_sym(1, 2'b01, 0); expect_sym(1, 2'b01, 0);
    expect_sym(1, 2'b00, 0); expect_sym(1, 2'b01, 0); expect_sym(1, 2'b01, 0);
    expect_sym(1, 2'b00, 0); expect_sym(1, 2'b10, 1); expect_sym(1, 2'b11, 1);
    send_bits(1, 16'b11011010, 8, 1'b1);
    send(1, 1'b1, 1'b1, w);
    check("noterm_gap_cycles", 32'(w), 32'd0);

    // Reset in the middle of a tail flush
    expect_sym(0, 2'b11, 0);
    send(0, 1'b1, 1'b1, w);
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_during_reset", 32'(bus0.o_ready), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("midtail_rst_valid", 32'(bus0.o_valid), 32'd0);
    check("midtail_rst_busy", 32'(busy0), 32'd0);
    check("midtail_rst_last", 32'(bus0.o_last), 32'd0);
    expect_sym(0, 2'b11, 0); expect_sym(0, 2'b10, 0); expect_sym(0, 2'b11, 1);
    send(0, 1'b1, 1'b1, w);

    // K=7 single-bit frame: impulse response of 171/133
    expect_sym(2, 2'b11, 0); expect_sym(2, 2'b10, 0); expect_sym(2, 2'b11, 0);
    expect_sym(2, 2'b11, 0); expect_sym(2, 2'b00, 0); expect_sym(2, 2'b01, 0);
    expect_sym(2, 2'b11, 1);
    send(2, 1'b1, 1'b1, w);

    for (int i = 0; i < 100; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    check("dut0_pending", 32'(exp_q[0].size()), 32'd0);
    check("dut1_pending", 32'(exp_q[1].size()), 32'd0);
    check("dut2_pending", 32'(exp_q[2].size()), 32'd0);
    check("idle_busy0", 32'(busy0), 32'd0);
    check("idle_busy2", 32'(busy2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
